knight_move_gen: RTL
====================

# knight_move_gen

Sequential move-generation stage for knights. It latches a board snapshot and a source square, then steps the eight knight directions one per cycle using the same 3-bit direction codes as the square scanner. It produces a registered 64-bit legal-destination mask, a capture mask and a move count. The move validator and the display/selection logic consume these results.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears FSM and all outputs
- start  input  1  request; sampled only in IDLE
- bigBoard  input  256  square i = bigBoard[4i+3:4i]; bit3 = colour (1 black), bits[2:0] = type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king)
- currentPosition  input  6  source square; row = pos/8 (row 0 = top), col = pos%8
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when results are valid
- error  output  1  source square is not a knight; valid with done, held until next start
- moveMask  output  64  bit t set = legal destination t
- captureMask  output  64  subset of moveMask where the target holds an enemy piece
- moveCount  output  4  popcount of moveMask, 0..8

## Operation
- States: IDLE, CHECK, SCAN, DONE.
- IDLE: if start=1, latch bigBoard and currentPosition into internal registers. Clear moveMask, captureMask, moveCount and error. Go to CHECK. The inputs are not used again until the next start.
- CHECK: if the source type is not 2, set error=1 and go to DONE. Otherwise set dir=0 and go to SCAN.
- SCAN: evaluate direction dir for one cycle. Offsets as (drow,dcol):
  - 000 (-1,-2), 001 (-2,-1), 010 (-2,+1), 011 (-1,+2)
  - 100 (+1,+2), 101 (+2,+1), 110 (+2,-1), 111 (+1,-2)
- A target counts only when row+drow and col+dcol are both in 0..7. Row and column are checked separately, so targets never wrap across an edge.
- For an in-range target t:
  - empty square: set moveMask[t]
  - enemy colour (colour differs from the source): set moveMask[t] and captureMask[t]
  - friendly piece: no change
- moveCount increments in the same cycle as each moveMask bit is set. After dir=7, go to DONE; otherwise dir increments.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs hold until the next accepted start or reset.
- King capture is reported like any other capture. Check and pin legality are out of scope.

## Timing
- Start accepted at edge E, valid source: CHECK after E, SCAN for edges E+2..E+9, done high in the cycle after E+10.
- Invalid source: done high in the cycle after E+2.
- busy goes high after E and low after the DONE cycle. The cycle after done shows busy=0.
- start while busy is ignored, with no queuing. start held high through DONE triggers a new run on the first IDLE cycle.
- Changes to bigBoard or currentPosition after E have no effect on the current run.
- Reset during any state: next state IDLE, all outputs 0, and no done pulse.
- Reset values: busy=0, done=0, error=0, moveMask=0, captureMask=0, moveCount=0.

## Structure
- Shared package chess_pkg holds:
  - piece type codes, the colour bit position and EMPTY
  - the eight direction localparams (UPLEFTLEFT=000 through LEFTLEFTDOWN=111)
  - square row/col helper functions
  - the 4-bit square width
- Sub-module knight_target: combinational; inputs pos[5:0] and dir[2:0]; outputs inRange and target[5:0]. This is shared with the scanner stage.
- FSM, snapshot registers and accumulation stay in knight_move_gen.

## Test plan
- White knight (4'b0010) at 0 on an otherwise empty board -> moveMask bits {10,17}, captureMask=0, moveCount=2, done 10 cycles after start.
- White knight at 27, empty board -> moveMask bits {10,12,17,21,33,37,42,44}, moveCount=8.
- White knight at 27, white pawn at 10, black rook (4'b1100) at 44 -> 10 cleared, 44 set in both masks, moveCount=7.
- Wrap-around: knight at 7 -> bits {13,22} only; knight at 56 -> bits {41,50} only; bits 16/15 never set.
- Source 27 empty -> error=1, masks 0, done 2 cycles after start. Then a second start with a valid knight -> error returns to 0.
- Reset asserted mid-SCAN -> all outputs 0 next cycle and no done. A start pulse during busy -> ignored, results match the original run.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg
// Shared definitions for the chess move-generation stages: piece type codes,
// the colour bit position inside a square nibble, the eight knight direction
// codes (shared with the square scanner) and square row/column helpers.
package chess_pkg;

    // Each square occupies one nibble of the board vector: bit 3 is colour
    // (1 = black), bits [2:0] are the piece type.
    localparam int SQ_W      = 4;
    localparam int COLOR_BIT = 3;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] KNIGHT = 3'd2;
    localparam logic [2:0] BISHOP = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;

    // Knight directions, (drow, dcol) with row 0 at the top of the board.
    localparam logic [2:0] UPLEFTLEFT     = 3'b000; // (-1,-2)
    localparam logic [2:0] UPUPLEFT       = 3'b001; // (-2,-1)
    localparam logic [2:0] UPUPRIGHT      = 3'b010; // (-2,+1)
    localparam logic [2:0] UPRIGHTRIGHT   = 3'b011; // (-1,+2)
    localparam logic [2:0] RIGHTRIGHTDOWN = 3'b100; // (+1,+2)
    localparam logic [2:0] DOWNDOWNRIGHT  = 3'b101; // (+2,+1)
    localparam logic [2:0] DOWNDOWNLEFT   = 3'b110; // (+2,-1)
    localparam logic [2:0] LEFTLEFTDOWN   = 3'b111; // (+1,-2)

    function automatic logic [2:0] sq_row(input logic [5:0] sq);
        return sq[5:3];
    endfunction

    function automatic logic [2:0] sq_col(input logic [5:0] sq);
        return sq[2:0];
    endfunction

endpackage

// File: rtl/knight_target.sv
// knight_target
// Combinational knight target calculator, shared with the scanner stage.
// Ports:
//   pos     [5:0] source square (row = pos/8, col = pos%8)
//   dir     [2:0] knight direction code from chess_pkg
//   inRange       target lies on the board (row and column checked separately)
//   target  [5:0] destination square; only meaningful when inRange = 1
module knight_target
    import chess_pkg::*;
(
    input  logic [5:0] pos,
    input  logic [2:0] dir,
    output logic       inRange,
    output logic [5:0] target
);

    logic signed [4:0] drow;
    logic signed [4:0] dcol;
    logic signed [4:0] row_s;
    logic signed [4:0] col_s;

    always_comb begin
        drow = 5'sd0;
        dcol = 5'sd0;
        case (dir)
            UPLEFTLEFT:     begin drow = -5'sd1; dcol = -5'sd2; end
            UPUPLEFT:       begin drow = -5'sd2; dcol = -5'sd1; end
            UPUPRIGHT:      begin drow = -5'sd2; dcol =  5'sd1; end
            UPRIGHTRIGHT:   begin drow = -5'sd1; dcol =  5'sd2; end
            RIGHTRIGHTDOWN: begin drow =  5'sd1; dcol =  5'sd2; end
            DOWNDOWNRIGHT:  begin drow =  5'sd2; dcol =  5'sd1; end
            DOWNDOWNLEFT:   begin drow =  5'sd2; dcol = -5'sd1; end
            LEFTLEFTDOWN:   begin drow =  5'sd1; dcol = -5'sd2; end
            default:        begin drow =  5'sd0; dcol =  5'sd0; end
        endcase
    end

    // Row and column are offset in a signed 5-bit space so that a step off
    // any edge shows up as a negative or >7 coordinate instead of wrapping
    // into the neighbouring row.
    always_comb begin
        row_s   = $signed({2'b00, sq_row(pos)}) + drow;
        col_s   = $signed({2'b00, sq_col(pos)}) + dcol;
        inRange = (row_s >= 5'sd0) && (row_s <= 5'sd7) &&
                  (col_s >= 5'sd0) && (col_s <= 5'sd7);
        target  = {row_s[2:0], col_s[2:0]};
    end

endmodule

// File: rtl/knight_move_gen.sv
// knight_move_gen
// Sequential knight move generator. Latches a board snapshot and a source
// square on start, then evaluates one knight direction per cycle, building
// a legal-destination mask, a capture mask and a move count.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               run request, sampled only while idle
//   bigBoard [255:0]    board, square i in bits [4i+3:4i]
//   currentPosition     source square
//   busy                high while a run is in progress
//   done                one-cycle pulse when results are valid
//   error               source square does not hold a knight
//   moveMask [63:0]     legal destinations
//   captureMask [63:0]  destinations holding an enemy piece
//   moveCount [3:0]     number of bits set in moveMask
module knight_move_gen
    import chess_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] bigBoard,
    input  logic [5:0]   currentPosition,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [63:0]  moveMask,
    output logic [63:0]  captureMask,
    output logic [3:0]   moveCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    dir_q, dir_d;
    logic [255:0]  board_q, board_d;
    logic [5:0]    pos_q, pos_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [63:0]   move_q, move_d;
    logic [63:0]   cap_q, cap_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [SQ_W-1:0] board_sq [64];
    logic [SQ_W-1:0] src_piece;
    logic [SQ_W-1:0] tgt_piece;
    logic            tgt_in_range;
    logic [5:0]      tgt_sq;

    // View the snapshot as 64 nibbles so source and target lookups are
    // plain array reads.
    for (genvar gi = 0; gi < 64; gi++) begin : g_unpack
        assign board_sq[gi] = board_q[gi*SQ_W +: SQ_W];
    end

    assign src_piece = board_sq[pos_q];
    assign tgt_piece = board_sq[tgt_sq];

    knight_target u_target (
        .pos     (pos_q),
        .dir     (dir_q),
        .inRange (tgt_in_range),
        .target  (tgt_sq)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        board_d = board_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        error_d = error_q;
        move_d  = move_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    board_d = bigBoard;
                    pos_d   = currentPosition;
                    move_d  = '0;
                    cap_d   = '0;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (src_piece[2:0] != KNIGHT) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    dir_d   = UPLEFTLEFT;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (tgt_in_range) begin
                    if (tgt_piece[2:0] == EMPTY) begin
                        move_d[tgt_sq] = 1'b1;
                        cnt_d          = cnt_q + 4'd1;
                    end else if (tgt_piece[COLOR_BIT] != src_piece[COLOR_BIT]) begin
                        move_d[tgt_sq] = 1'b1;
                        cap_d[tgt_sq]  = 1'b1;
                        cnt_d          = cnt_q + 4'd1;
                    end
                end
                if (dir_q == LEFTLEFTDOWN) begin
                    state_d = DONE;
                end else begin
                    dir_d = dir_q + 3'd1;
                end
            end
            DONE: begin
                // The done pulse is registered, so it appears in the first
                // IDLE cycle, alongside busy already low.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            move_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            move_q  <= move_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    // The snapshot is only read after a start has loaded it, so it needs no
    // reset.
    always_ff @(posedge clk) begin
        board_q <= board_d;
        pos_q   <= pos_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign moveMask    = move_q;
    assign captureMask = cap_q;
    assign moveCount   = cnt_q;

endmodule
